// File: rtl/fp_pkg.sv
// Shared FP32 constants and packed result/flag types for the mul/div datapath.
package fp_pkg;
    localparam int          BIAS    = 127;
    localparam int          EXP_MAX = 255;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef struct packed {
        logic of;
        logic uf;
        logic nx;
    } fp_flags_t;
endpackage

// File: rtl/lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module lzc #(
    parameter int W = 48
) (
    input  logic [W-1:0]           d,
    output logic [$clog2(W+1)-1:0] cnt
);
    always_comb begin
        cnt = ($clog2(W+1))'(W);
        // ascending scan: the highest set bit is the last to write cnt
        for (int i = 0; i < W; i++)
            if (d[i]) cnt = ($clog2(W+1))'(W - 1 - i);
    end
endmodule

// File: rtl/fp_norm_round.sv
// FP32 normalise / round-nearest-even / pack, three stages, valid-ready with global enable.
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int MANT_W = 48,
    parameter int FRAC_W = 23,
    parameter int EXP_W  = 10
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_in,
    input  logic [EXP_W-1:0]  e_in,
    input  logic [MANT_W-1:0] m_in,
    input  logic              nan_in,
    input  logic              inf_in,
    input  logic              zero_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       result,
    output logic              flag_of,
    output logic              flag_uf,
    output logic              flag_nx
);
    localparam int STAGES = 3;
    localparam int LZ_W   = $clog2(MANT_W + 1);
    localparam int E_W    = 12;
    localparam int GB     = MANT_W - 2 - FRAC_W;

    logic            advance;
    logic [STAGES:1] vld_pipe;

    assign advance   = en & (~out_valid | out_ready);
    assign in_ready  = advance;
    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk or posedge arst)
        if (arst)         vld_pipe <= '0;
        else if (advance) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};

    // ---- S1: normalise so the leading one lands on the MSB
    logic [LZ_W-1:0]       lz;
    logic [MANT_W-1:0]     m_n;
    logic signed [E_W-1:0] e1;

    lzc #(.W(MANT_W)) u_lzc (.d(m_in), .cnt(lz));

    assign m_n = m_in << lz;
    assign e1  = {{(E_W-EXP_W){e_in[EXP_W-1]}}, e_in} + E_W'(1) - {{(E_W-LZ_W){1'b0}}, lz};

    logic                  s1_sign, s1_nan, s1_inf, s1_zero;
    logic signed [E_W-1:0] s1_e;
    logic [MANT_W-1:0]     s1_m;

    always_ff @(posedge clk or posedge arst)
        if (arst) begin
            {s1_sign, s1_nan, s1_inf, s1_zero} <= '0;
            s1_e <= '0;
            s1_m <= '0;
        end else if (advance) begin
            {s1_sign, s1_nan, s1_inf, s1_zero} <= {sign_in, nan_in, inf_in, zero_in};
            s1_e <= e1;
            s1_m <= m_n;
        end

    // ---- S2: round to nearest even; a normalised MSB of 0 means the mantissa was zero
    logic [FRAC_W-1:0]     frac, frac_r;
    logic                  g, r, s, up, c;
    logic signed [E_W-1:0] e2;

    assign frac        = s1_m[MANT_W-2 -: FRAC_W];
    assign g           = s1_m[GB];
    assign r           = s1_m[GB-1];
    assign s           = |s1_m[GB-2:0];
    assign up          = g & (r | s | frac[0]);
    assign {c, frac_r} = {1'b0, frac} + (FRAC_W+1)'(up);
    assign e2          = s1_e + E_W'(c);

    logic                  s2_sign, s2_nan, s2_inf, s2_zero, s2_nx;
    logic signed [E_W-1:0] s2_e;
    logic [FRAC_W-1:0]     s2_frac;

    always_ff @(posedge clk or posedge arst)
        if (arst) begin
            {s2_sign, s2_nan, s2_inf, s2_zero, s2_nx} <= '0;
            s2_e    <= '0;
            s2_frac <= '0;
        end else if (advance) begin
            {s2_sign, s2_nan, s2_inf, s2_zero} <= {s1_sign, s1_nan, s1_inf, s1_zero | ~s1_m[MANT_W-1]};
            s2_nx   <= g | r | s;
            s2_e    <= e2;
            s2_frac <= frac_r;
        end

    // ---- S3: special-case priority and packing
    fp32_t     pk, res_q;
    fp_flags_t fl, flg_q;

    always_comb begin
        pk = '0;
        fl = '0;
        if (s2_nan)
            pk = QNAN;
        else if (s2_inf)
            pk = {s2_sign, 8'hFF, 23'h0};
        else if (s2_zero)
            pk = {s2_sign, 31'h0};
        else if (s2_e >= E_W'(EXP_MAX)) begin
            pk    = {s2_sign, 8'hFF, 23'h0};
            fl.of = 1'b1;
            fl.nx = 1'b1;
        end else if (s2_e <= E_W'(0)) begin
            pk    = {s2_sign, 31'h0};
            fl.uf = 1'b1;
            fl.nx = 1'b1;
        end else begin
            pk    = {s2_sign, s2_e[7:0], s2_frac};
            fl.nx = s2_nx;
        end
    end

    always_ff @(posedge clk or posedge arst)
        if (arst) begin
            res_q <= '0;
            flg_q <= '0;
        end else if (advance) begin
            res_q <= pk;
            flg_q <= fl;
        end

    assign result  = res_q;
    assign flag_of = flg_q.of;
    assign flag_uf = flg_q.uf;
    assign flag_nx = flg_q.nx;
endmodule
